// File: rtl/pipe_elastic.sv
// Elastic register pipeline: DEPTH valid/data stages with a combinational
// bubble-collapsing ready chain, registered outputs and an occupancy count.
module pipe_elastic #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;

  // ready[k]: stage k may take a new entry at the next edge; ready[DEPTH] is downstream
  logic [DEPTH:0]   ready;
  // src_*[k]: what stage k would load (upstream stage, or the input port for stage 0)
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic             accept;

  assign in_ready = ready[0] && !flush && rst_n;
  assign accept   = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign src_valid[gi] = accept;
        assign src_data[gi]  = in_data;
      end else begin : g_body
        assign src_valid[gi] = valid_reg[gi-1];
        assign src_data[gi]  = data_reg[gi-1];
      end
    end
  endgenerate

  // Ready chain: a stage can load if empty or if its own entry moves on this edge
  always_comb begin
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready[k] = !valid_reg[k] || ready[k+1];
    end
  end

  // Next valid bits and occupancy; flush empties every stage
  always_comb begin
    valid_next = valid_reg;
    count_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ready[k]) begin
        valid_next[k] = src_valid[k];
      end
    end
    if (flush) begin
      valid_next = '0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      count_next = count_next + CW'(valid_next[k]);
    end
  end

  // Valid bits and count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  // Data registers load only when a valid entry moves in; otherwise they hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!flush && ready[k] && src_valid[k]) begin
          data_reg[k] <= src_data[k];
        end
      end
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_data  = data_reg[DEPTH-1];
  assign count     = count_reg;

endmodule

// File: tb/tb_pipe_elastic.sv
// Self-checking bench for pipe_elastic (WIDTH=8, DEPTH=3): directed scenarios
// plus a randomized run against a position-based reference model.
module tb_pipe_elastic;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int CW = $clog2(D+1);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of held entries (oldest first) with their stage index
  int           mpos[$];
  logic [W-1:0] mdat[$];

  pipe_elastic #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per output transfer
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready)
      $display("out xfer data=0x%02h count=%0d", out_data, count);
  end

  // Each entry advances one stage per edge unless blocked by the entry ahead
  function automatic bit m_ready(input bit ordy, input bit fl);
    int lim;
    int s;
    int np;
    lim = D;
    s = 0;
    if (fl) return 1'b0;
    if (mpos.size() > 0 && ordy && mpos[0] == D-1) s = 1;
    for (int i = s; i < mpos.size(); i++) begin
      np = mpos[i] + 1;
      if (np > lim - 1) np = lim - 1;
      lim = np;
    end
    return lim > 0;
  endfunction

  task automatic m_edge(input bit iv, input bit ordy, input bit fl, input logic [W-1:0] id);
    bit acc;
    int lim;
    int np;
    acc = iv && m_ready(ordy, fl);
    if (mpos.size() > 0 && ordy && mpos[0] == D-1) begin
      void'(mpos.pop_front());
      void'(mdat.pop_front());
    end
    if (fl) begin
      mpos.delete();
      mdat.delete();
      return;
    end
    lim = D;
    for (int i = 0; i < mpos.size(); i++) begin
      np = mpos[i] + 1;
      if (np > lim - 1) np = lim - 1;
      mpos[i] = np;
      lim = np;
    end
    if (acc) begin
      mpos.push_back(0);
      mdat.push_back(id);
    end
  endtask

  // Advance model and DUT by one edge; returns at posedge+1
  task automatic tick();
    m_edge(in_valid, out_ready, flush, in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream();
    for (int cyc = 0; cyc < 14; cyc++) begin
      checks++; if (out_valid !== (cyc >= 3 && cyc <= 12)) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", cyc, out_valid, (cyc >= 3 && cyc <= 12)); end
      if (cyc >= 3 && cyc <= 12) begin
        checks++; if (out_data !== 8'(cyc - 2)) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", cyc, out_data, 8'(cyc - 2)); end
      end
      if (cyc >= 3 && cyc <= 10) begin
        checks++; if (count !== 2'd3) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected 3", cyc, count); end
      end
      in_valid = (cyc < 10); in_data = 8'(cyc + 1); out_ready = 1'b1; flush = 1'b0;
      #1;
      if (cyc < 10) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", cyc, in_ready); end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] exp_q[$];
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hA1 + 8'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick();
    end
    in_valid = 1'b1; in_data = 8'hEE;
    #1;
    checks++; if (count !== 2'd3) begin errors++; $display("FAIL full_count: got %0d expected 3", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin errors++; $display("FAIL full_head: got %b/%h expected 1/a1", out_valid, out_data); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out_data !== 8'hA1 || count !== 2'd3) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%0d expected a1/3", i, out_data, count); end
    end
    out_ready = 1'b1; in_data = 8'hB4;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pass_in_ready: got %b expected 1", in_ready); end
    tick();
    checks++; if (out_data !== 8'hA2 || count !== 2'd3) begin errors++; $display("FAIL full_pass: got %h/%0d expected a2/3", out_data, count); end
    in_valid = 1'b0;
    exp_q = '{8'hA3, 8'hB4};
    foreach (exp_q[i]) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin errors++; $display("FAIL drain[%0d]: got %b/%h expected 1/%h", i, out_valid, out_data, exp_q[i]); end
    end
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL drain_empty: got %b/%0d expected 0/0", out_valid, count); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h22; tick();
    in_valid = 1'b0;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL bubble_count: got %0d expected 2", count); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || count !== 2'd2) begin errors++; $display("FAIL bubble_head: got %b/%h/%0d expected 1/11/2", out_valid, out_data, count); end
    out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h22 || count !== 2'd1) begin errors++; $display("FAIL bubble_second: got %b/%h/%0d expected 1/22/1", out_valid, out_data, count); end
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL bubble_empty: got %b/%0d expected 0/0", out_valid, count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hC1; tick();
    in_data = 8'hC2; tick();
    in_valid = 1'b0;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d expected 2", count); end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got %0d/%b expected 0/0", count, out_valid); end
    out_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %0d/%b expected 0/0", count, out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hD1 + 8'(i); tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 2'd3) begin errors++; $display("FAIL areset_pre_count: got %0d expected 3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== 2'd0) begin errors++; $display("FAIL areset_immediate: got %b/%h/%0d expected 0/00/0", out_valid, out_data, count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready: got %b expected 0", in_ready); end
    mpos.delete();
    mdat.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_release_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_no_partial[%0d]: got %b expected 0", i, out_valid); end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || count !== 2'd1) begin errors++; $display("FAIL areset_new_data: got %b/%h/%0d expected 1/5a/1", out_valid, out_data, count); end
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL areset_drained: got %b/%0d expected 0/0", out_valid, count); end
  endtask

  task automatic test_random();
    bit           exp_v;
    bit           exp_r;
    for (int n = 0; n < 400; n++) begin
      exp_v = (mpos.size() > 0 && mpos[0] == D-1);
      checks++; if (count !== CW'(mpos.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, count, mpos.size()); end
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_data !== mdat[0]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, out_data, mdat[0]); end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = 8'($urandom);
      #1;
      exp_r = m_ready(out_ready, flush);
      checks++; if (in_ready !== exp_r) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", n, in_ready, exp_r); end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    checks++; if (out_valid !== 1'b0 || count !== 2'd0 || mpos.size() != 0) begin errors++; $display("FAIL rand_final_empty: got %b/%0d expected 0/0", out_valid, count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_drain();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_elastic.md
PIPE_ELASTIC -- requirements
Module: pipe_elastic

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits (legal values 1 or more).
REQ-002 The block SHALL have parameter DEPTH, default 3, meaning the number of register stages (legal values 1 or more).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream presents in_data.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the last stage holds an entry.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: payload of the last stage.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+1) bits: number of occupied stages.

Function
REQ-013 Each stage k (0..DEPTH-1) SHALL hold a valid bit v[k] and a WIDTH-bit data register d[k]; stage 0 is input side, stage DEPTH-1 drives out_valid/out_data directly (registered outputs, no combinational data path from in_data).
REQ-014 Input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; output transfer where out_valid and out_ready are both 1.
REQ-015 Stage DEPTH-1 SHALL be able to load when v[DEPTH-1]=0 or out_ready=1; stage k<DEPTH-1 SHALL be able to load when v[k]=0 or stage k+1 advances (bubble-collapsing ready chain, combinational, no extra cycle).
REQ-016 in_ready SHALL equal (stage 0 can load) AND NOT flush.
REQ-017 An entry accepted at edge N into an empty, unstalled pipe SHALL appear with out_valid=1 after edge N+DEPTH-1 (DEPTH-cycle latency counting the accept edge as cycle 1).
REQ-018 With in_valid=1 and out_ready=1 held, throughput SHALL be one entry per cycle with no bubbles.
REQ-019 A stage whose contents cannot advance SHALL hold v[k] and d[k] unchanged; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 Internal bubbles SHALL be squeezed out: an empty stage downstream of a stalled full stage SHALL be filled on the next edge.
REQ-021 Entries SHALL leave in strict acceptance order; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-022 count SHALL be the registered sum of v[0..DEPTH-1], updated on the same edge as the valid bits; range 0..DEPTH.
REQ-023 Full condition (count=DEPTH, out_ready=0) SHALL force in_ready=0; full with out_ready=1 SHALL keep in_ready=1 (simultaneous in/out transfer, count unchanged).
REQ-024 Flush=1 at an edge SHALL clear all v[k] and set count to 0 on that edge; no input is accepted that cycle; an output transfer presented in that cycle still counts as completed.
REQ-025 Flush SHALL not modify d[k]; data registers of invalid stages are don't-care, but only valid entries SHALL ever be presented with out_valid=1.
REQ-026 For DEPTH=1, the block SHALL behave as a single full-throughput register slice with in_ready = NOT v[0] OR out_ready, gated by NOT flush.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force all v[k]=0, all d[k]=0, out_valid=0, out_data=0, count=0.
REQ-028 While rst_n=0, in_ready SHALL be 0; the first input transfer SHALL be possible at the first rising edge after rst_n deasserts.
REQ-029 Reset asserted mid-stream SHALL discard all held entries; no partial entry SHALL emerge after release.

Verification (WIDTH=8, DEPTH=3)
REQ-030 Stream 0x01..0x0A, in_valid=1 and out_ready=1 continuous -> 0x01 visible after the 3rd edge, then one value per cycle in order, count settles at 3.
REQ-031 Fill with 0xA1,0xA2,0xA3 while out_ready=0 -> count=3, in_ready=0, out_data=0xA1 stable; raising out_ready drains A1,A2,A3 on consecutive edges.
REQ-032 Full pipe, out_ready=1, in_valid=1 with 0xB4 -> A1 leaves and B4 enters on the same edge, count stays 3.
REQ-033 Insert 0x11, idle one cycle, insert 0x22 with out_ready=0 -> bubble collapses, count=2, output order 0x11 then 0x22.
REQ-034 Count=2, flush=1 with in_valid=1 -> in_ready=0, next edge count=0, out_valid=0, offered word not accepted.
REQ-035 Count=3, pulse rst_n low between clock edges -> out_valid, out_data, count go to 0 immediately; after release the pipe accepts new data normally.
